// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit layout and default datapath widths.
package pipe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned CTRL_W = 8;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_JUMP     = 6;
    localparam int unsigned CTRL_HALT     = 7;

endpackage

// File: rtl/pipe_field.sv
// Generic pipeline field register: async active-low reset, hold-enable and synchronous clear.
// Clear dominates enable, so a squash still lands while the stage is held.
module pipe_field #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush > stall > bubble > load priority.
// Optional bubble/flush performance counters when ID_EX_PERF_CNT_EN is defined.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = pipe_pkg::DATA_W,
    parameter int unsigned REG_W  = pipe_pkg::REG_W,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_id_ex,
    input  logic              flush_id_ex,
    input  logic              zero_control_signals,
    input  logic              valid_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [DATA_W-1:0] pc_plus2_id,
    input  logic [DATA_W-1:0] rd1_id,
    input  logic [DATA_W-1:0] rd2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic [REG_W-1:0]  rs_id,
    input  logic [REG_W-1:0]  rt_id,
    input  logic [REG_W-1:0]  rd_id,
    input  logic              rs_valid_id,
    input  logic              rt_valid_id,
    output logic              valid_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic              MemRead_id_ex,
    output logic [DATA_W-1:0] pc_plus2_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [REG_W-1:0]  rs_ex,
    output logic [REG_W-1:0]  rt_ex,
    output logic [REG_W-1:0]  rd_ex,
`ifdef ID_EX_PERF_CNT_EN
    output logic [15:0]       bubble_cnt,
    output logic [15:0]       flush_cnt,
`endif
    output logic              rs_valid_ex,
    output logic              Rt_valid_id_ex
);

    localparam int unsigned CtlGrpW  = CTRL_W + 3;
    localparam int unsigned DataGrpW = 4 * DATA_W;
    localparam int unsigned SpecGrpW = 3 * REG_W;

    logic                en;
    logic                clr;
    logic                bubble_evt;
    logic [CtlGrpW-1:0]  ctl_grp_d, ctl_grp_q;
    logic [DataGrpW-1:0] data_grp_q;
    logic [SpecGrpW-1:0] spec_grp_q;

    assign en         = ~stall_id_ex;
    assign bubble_evt = zero_control_signals & ~stall_id_ex & ~flush_id_ex;
    assign clr        = flush_id_ex | bubble_evt;

    // Invalid entries carry no control or specifier-valid bits, so they can never act.
    always_comb begin
        ctl_grp_d = '0;
        if (valid_id) begin
            ctl_grp_d = {1'b1, ctrl_id, rs_valid_id, rt_valid_id};
        end
    end

    pipe_field #(.Width(CtlGrpW)) u_ctl_field (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .clr_i (clr),
        .d_i   (ctl_grp_d),
        .q_o   (ctl_grp_q)
    );

    pipe_field #(.Width(DataGrpW)) u_data_field (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .clr_i (clr),
        .d_i   ({pc_plus2_id, rd1_id, rd2_id, imm_id}),
        .q_o   (data_grp_q)
    );

    pipe_field #(.Width(SpecGrpW)) u_spec_field (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .clr_i (clr),
        .d_i   ({rs_id, rt_id, rd_id}),
        .q_o   (spec_grp_q)
    );

    assign {valid_ex, ctrl_ex, rs_valid_ex, Rt_valid_id_ex} = ctl_grp_q;
    assign {pc_plus2_ex, rd1_ex, rd2_ex, imm_ex}            = data_grp_q;
    assign {rs_ex, rt_ex, rd_ex}                            = spec_grp_q;
    assign MemRead_id_ex = ctrl_ex[CTRL_MEMREAD];

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (flush_id_ex && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; checks counters when ID_EX_PERF_CNT_EN is set.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_id_ex, flush_id_ex, zero_control_signals, valid_id;
    logic [7:0]  ctrl_id;
    logic [15:0] pc_plus2_id, rd1_id, rd2_id, imm_id;
    logic [2:0]  rs_id, rt_id, rd_id;
    logic        rs_valid_id, rt_valid_id;
    logic        valid_ex, MemRead_id_ex, rs_valid_ex, Rt_valid_id_ex;
    logic [7:0]  ctrl_ex;
    logic [15:0] pc_plus2_ex, rd1_ex, rd2_ex, imm_ex;
    logic [2:0]  rs_ex, rt_ex, rd_ex;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bubble_cnt, flush_cnt;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .stall_id_ex          (stall_id_ex),
        .flush_id_ex          (flush_id_ex),
        .zero_control_signals (zero_control_signals),
        .valid_id             (valid_id),
        .ctrl_id              (ctrl_id),
        .pc_plus2_id          (pc_plus2_id),
        .rd1_id               (rd1_id),
        .rd2_id               (rd2_id),
        .imm_id               (imm_id),
        .rs_id                (rs_id),
        .rt_id                (rt_id),
        .rd_id                (rd_id),
        .rs_valid_id          (rs_valid_id),
        .rt_valid_id          (rt_valid_id),
        .valid_ex             (valid_ex),
        .ctrl_ex              (ctrl_ex),
        .MemRead_id_ex        (MemRead_id_ex),
        .pc_plus2_ex          (pc_plus2_ex),
        .rd1_ex               (rd1_ex),
        .rd2_ex               (rd2_ex),
        .imm_ex               (imm_ex),
        .rs_ex                (rs_ex),
        .rt_ex                (rt_ex),
        .rd_ex                (rd_ex),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt           (bubble_cnt),
        .flush_cnt            (flush_cnt),
`endif
        .rs_valid_ex          (rs_valid_ex),
        .Rt_valid_id_ex       (Rt_valid_id_ex)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic v, input logic [7:0] c, input logic [15:0] pc,
                              input logic [15:0] r1, input logic [15:0] r2,
                              input logic [15:0] im, input logic [2:0] s, input logic [2:0] t,
                              input logic [2:0] d, input logic sv, input logic tv);
        valid_id = v; ctrl_id = c; pc_plus2_id = pc; rd1_id = r1; rd2_id = r2; imm_id = im;
        rs_id = s; rt_id = t; rd_id = d; rs_valid_id = sv; rt_valid_id = tv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall_id_ex = 1'b0; flush_id_ex = 1'b0; zero_control_signals = 1'b0;
        set_inputs(1'b1, 8'hFF, 16'hAAAA, 16'h5555, 16'h3333, 16'hCCCC, 3'd7, 3'd6, 3'd5,
                   1'b1, 1'b1);
        #12 rst_n = 1'b1;
        tick();
        checks++; if (ctrl_ex !== 8'hFF) $display("FAIL rst_preload_ctrl: got %h want ff", ctrl_ex); else passes++;
        // Assert reset mid-cycle, check before the next edge.
        #3 rst_n = 1'b0;
        #1;
        checks++; if (valid_ex !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_ex); else passes++;
        checks++; if (ctrl_ex !== 8'h00 || MemRead_id_ex !== 1'b0) $display("FAIL rst_ctrl: got %h/%b want 00/0", ctrl_ex, MemRead_id_ex); else passes++;
        checks++; if ({pc_plus2_ex, rd1_ex, rd2_ex, imm_ex} !== 64'h0) $display("FAIL rst_data: got %h %h %h %h want 0", pc_plus2_ex, rd1_ex, rd2_ex, imm_ex); else passes++;
        checks++; if ({rs_ex, rt_ex, rd_ex, rs_valid_ex, Rt_valid_id_ex} !== 11'h0) $display("FAIL rst_spec: got %h want 0", {rs_ex, rt_ex, rd_ex, rs_valid_ex, Rt_valid_id_ex}); else passes++;
`ifdef ID_EX_PERF_CNT_EN
        checks++; if (bubble_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", bubble_cnt, flush_cnt); else passes++;
`endif
        #2 rst_n = 1'b1;
        tick();
        checks++; if (valid_ex !== 1'b1) $display("FAIL rst_release_load: got %b want 1", valid_ex); else passes++;
    endtask

    task automatic test_normal_load();
        set_inputs(1'b1, 8'h03, 16'h0010, 16'h1234, 16'hBEEF, 16'hFFF0, 3'd2, 3'd5, 3'd7,
                   1'b1, 1'b1);
        tick();
        checks++; if (valid_ex !== 1'b1) $display("FAIL load_valid: got %b want 1", valid_ex); else passes++;
        checks++; if (MemRead_id_ex !== 1'b1 || ctrl_ex !== 8'h03) $display("FAIL load_ctrl: got %h/%b want 03/1", ctrl_ex, MemRead_id_ex); else passes++;
        checks++; if (rd1_ex !== 16'h1234 || rd2_ex !== 16'hBEEF || imm_ex !== 16'hFFF0 || pc_plus2_ex !== 16'h0010) $display("FAIL load_data: got %h %h %h %h", pc_plus2_ex, rd1_ex, rd2_ex, imm_ex); else passes++;
        checks++; if (rt_ex !== 3'd5 || rs_ex !== 3'd2 || rd_ex !== 3'd7) $display("FAIL load_spec: got %0d %0d %0d want 2 5 7", rs_ex, rt_ex, rd_ex); else passes++;
        checks++; if (Rt_valid_id_ex !== 1'b1 || rs_valid_ex !== 1'b1) $display("FAIL load_spec_valid: got %b%b want 11", rs_valid_ex, Rt_valid_id_ex); else passes++;
    endtask

    task automatic test_bubble();
        zero_control_signals = 1'b1;
        set_inputs(1'b1, 8'hFF, 16'h0012, 16'h4321, 16'h1111, 16'h0001, 3'd1, 3'd4, 3'd3,
                   1'b1, 1'b1);
        tick();
        zero_control_signals = 1'b0;
        checks++; if (valid_ex !== 1'b0) $display("FAIL bubble_valid: got %b want 0", valid_ex); else passes++;
        checks++; if (ctrl_ex !== 8'h00 || Rt_valid_id_ex !== 1'b0 || rs_valid_ex !== 1'b0) $display("FAIL bubble_ctrl: got %h %b %b want 00 0 0", ctrl_ex, rs_valid_ex, Rt_valid_id_ex); else passes++;
        checks++; if (rd1_ex !== 16'h0 || rt_ex !== 3'd0) $display("FAIL bubble_data: got %h %0d want 0 0", rd1_ex, rt_ex); else passes++;
`ifdef ID_EX_PERF_CNT_EN
        checks++; if (bubble_cnt !== 16'd1) $display("FAIL bubble_cnt: got %0d want 1", bubble_cnt); else passes++;
`endif
    endtask

    task automatic test_stall_hold();
        set_inputs(1'b1, 8'h05, 16'h0020, 16'h5555, 16'h6666, 16'h0007, 3'd1, 3'd3, 3'd6,
                   1'b0, 1'b1);
        tick();
        stall_id_ex = 1'b1;
        zero_control_signals = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inputs(i[0], 8'h10 + 8'(i), 16'h9000 + 16'(i), 16'hA000 + 16'(i), 16'h0, 16'h0,
                       3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
            tick();
            checks++; if (valid_ex !== 1'b1 || ctrl_ex !== 8'h05) $display("FAIL stall_ctrl[%0d]: got %b/%h want 1/05", i, valid_ex, ctrl_ex); else passes++;
            checks++; if (rd1_ex !== 16'h5555 || pc_plus2_ex !== 16'h0020 || rt_ex !== 3'd3 || Rt_valid_id_ex !== 1'b1 || rs_valid_ex !== 1'b0) $display("FAIL stall_data[%0d]: got %h %h %0d %b%b", i, pc_plus2_ex, rd1_ex, rt_ex, rs_valid_ex, Rt_valid_id_ex); else passes++;
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++; if (bubble_cnt !== 16'd1) $display("FAIL stall_bubble_cnt: got %0d want 1", bubble_cnt); else passes++;
`endif
        zero_control_signals = 1'b0;
    endtask

    task automatic test_flush_beats_stall();
        flush_id_ex = 1'b1;
        tick();
        flush_id_ex = 1'b0;
        stall_id_ex = 1'b0;
        checks++; if (valid_ex !== 1'b0 || ctrl_ex !== 8'h00) $display("FAIL flush_ctrl: got %b/%h want 0/00", valid_ex, ctrl_ex); else passes++;
        checks++; if ({pc_plus2_ex, rd1_ex, rd2_ex, imm_ex, rs_ex, rt_ex, rd_ex} !== 73'h0 || rs_valid_ex !== 1'b0 || Rt_valid_id_ex !== 1'b0) $display("FAIL flush_all: got %h %h %0d want 0", pc_plus2_ex, rd1_ex, rt_ex); else passes++;
`ifdef ID_EX_PERF_CNT_EN
        checks++; if (flush_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", flush_cnt); else passes++;
`endif
    endtask

    task automatic test_invalid_load();
        set_inputs(1'b0, 8'h81, 16'h0030, 16'hA5A5, 16'h5A5A, 16'h0042, 3'd4, 3'd2, 3'd1,
                   1'b1, 1'b1);
        tick();
        checks++; if (valid_ex !== 1'b0 || ctrl_ex !== 8'h00) $display("FAIL inval_ctrl: got %b/%h want 0/00", valid_ex, ctrl_ex); else passes++;
        checks++; if (rs_valid_ex !== 1'b0 || Rt_valid_id_ex !== 1'b0) $display("FAIL inval_spec_valid: got %b%b want 00", rs_valid_ex, Rt_valid_id_ex); else passes++;
        checks++; if (rd1_ex !== 16'hA5A5 || imm_ex !== 16'h0042 || rs_ex !== 3'd4) $display("FAIL inval_data: got %h %h %0d want a5a5 0042 4", rd1_ex, imm_ex, rs_ex); else passes++;
    endtask

    task automatic test_back_to_back();
        set_inputs(1'b1, 8'h09, 16'h0040, 16'h1111, 16'h0, 16'h0, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0);
        tick();
        set_inputs(1'b1, 8'h02, 16'h0042, 16'h2222, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2, 1'b0, 1'b1);
        checks++; if (rd1_ex !== 16'h1111 || ctrl_ex !== 8'h09 || MemRead_id_ex !== 1'b0) $display("FAIL b2b_first: got %h %h %b want 1111 09 0", rd1_ex, ctrl_ex, MemRead_id_ex); else passes++;
        tick();
        checks++; if (rd1_ex !== 16'h2222 || ctrl_ex !== 8'h02 || MemRead_id_ex !== 1'b1 || Rt_valid_id_ex !== 1'b1) $display("FAIL b2b_second: got %h %h %b %b want 2222 02 1 1", rd1_ex, ctrl_ex, MemRead_id_ex, Rt_valid_id_ex); else passes++;
        // Flush without stall also squashes.
        flush_id_ex = 1'b1;
        tick();
        flush_id_ex = 1'b0;
        checks++; if (valid_ex !== 1'b0 || rd1_ex !== 16'h0) $display("FAIL b2b_flush: got %b %h want 0 0000", valid_ex, rd1_ex); else passes++;
`ifdef ID_EX_PERF_CNT_EN
        checks++; if (flush_cnt !== 16'd2 || bubble_cnt !== 16'd1) $display("FAIL b2b_cnt: got %0d/%0d want 2/1", flush_cnt, bubble_cnt); else passes++;
`endif
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bubble();
        test_stall_hold();
        test_flush_beats_stall();
        test_invalid_load();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
